// File: rtl/seq_detector_param.sv
// Parametrised Moore serial pattern detector with overlap/non-overlap mode,
// input qualifier, run-time pattern reload and a saturating match counter.
module seq_detector_param #(
   parameter int                   PATTERN_W = 4,
   parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
   parameter int                   CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 seq_in,
   input  logic                 in_valid,
   input  logic                 overlap_en,
   input  logic                 cfg_load,
   input  logic [PATTERN_W-1:0] cfg_pattern,
   output logic                 detect_out,
   output logic [CNT_W-1:0]     match_count
);

   localparam int                FILL_W   = $clog2(PATTERN_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W);

   logic [PATTERN_W-1:0] pat_q,  pat_d;
   logic [PATTERN_W-1:0] hist_q, hist_d;
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic                 det_q,  det_d;
   logic [CNT_W-1:0]     cnt_q,  cnt_d;

   logic [PATTERN_W-1:0] hist_nxt;
   logic [FILL_W-1:0]    fill_nxt;
   logic                 match;

   always_comb begin
      hist_nxt = {hist_q[PATTERN_W-2:0], seq_in};
      fill_nxt = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
      match    = (hist_nxt == pat_q) && (fill_nxt == FILL_MAX);
   end

   always_comb begin
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      det_d  = 1'b0;
      cnt_d  = cnt_q;
      if (cfg_load) begin
         pat_d  = cfg_pattern;
         hist_d = '0;
         fill_d = '0;
      end else if (in_valid) begin
         hist_d = hist_nxt;
         det_d  = match;
         // Non-overlap restarts the fill count so the next match needs fresh bits.
         fill_d = (match && !overlap_en) ? '0 : fill_nxt;
         if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pat_q  <= PATTERN;
         hist_q <= '0;
         fill_q <= '0;
         det_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         det_q  <= det_d;
         cnt_q  <= cnt_d;
      end
   end

   assign detect_out  = det_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: fixed vector table, directed corner sequences,
// and randomized traffic checked against a window-matching reference model.
module tb_seq_detector_param;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n, v, b, ovl, ld;
   logic [W-1:0] p;
   logic         det;
   logic [7:0]   cnt;

   logic         s_rst, s_v, s_b, s_ovl;
   logic         s_det;
   logic [1:0]   s_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_detector_param #(.PATTERN_W(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut (
      .clk(clk), .reset(rst_n), .seq_in(b), .in_valid(v), .overlap_en(ovl),
      .cfg_load(ld), .cfg_pattern(p), .detect_out(det), .match_count(cnt)
   );

   seq_detector_param #(.PATTERN_W(4), .PATTERN(4'b1111), .CNT_W(2)) u_sat (
      .clk(clk), .reset(s_rst), .seq_in(s_b), .in_valid(s_v), .overlap_en(s_ovl),
      .cfg_load(1'b0), .cfg_pattern(4'b0000), .detect_out(s_det), .match_count(s_cnt)
   );

   // Reference: accepted bits since last restart, plus the index from which
   // bits may still contribute to a match (moves past each non-overlap hit).
   logic         mq[$];
   int           fresh;
   logic [W-1:0] mpat;
   logic         edet;
   int           ecnt;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic vv, input logic bb,
                             input logic oo, input logic ll, input logic [W-1:0] pp);
      int  n;
      bit  m;
      if (!r) begin
         mpat = 4'b1011; mq.delete(); fresh = 0; edet = 0; ecnt = 0;
      end else if (ll) begin
         mpat = pp; mq.delete(); fresh = 0; edet = 0;
      end else if (vv) begin
         mq.push_back(bb);
         n = mq.size();
         m = (n - fresh) >= W;
         for (int i = 0; i < W; i++)
            if (m && (mq[n-W+i] != mpat[W-1-i])) m = 0;
         edet = m;
         if (m) begin
            if (ecnt < 255) ecnt++;
            if (!oo) fresh = n;
         end
         if (mq.size() > 32) begin
            void'(mq.pop_front());
            if (fresh > 0) fresh--;
         end
      end else begin
         edet = 0;
      end
   endtask

   task automatic step(input logic r, input logic vv, input logic bb,
                       input logic oo, input logic ll, input logic [W-1:0] pp);
      rst_n = r; v = vv; b = bb; ovl = oo; ld = ll; p = pp;
      @(posedge clk);
      model_edge(r, vv, bb, oo, ll, pp);
      #1;
      chk("model_det", int'(det), int'(edet));
      chk("model_cnt", int'(cnt), ecnt);
   endtask

   task automatic bit_in(input logic bb, input logic oo);
      step(1'b1, 1'b1, bb, oo, 1'b0, 4'b0000);
   endtask

   typedef struct {
      logic r, vv, bb, oo;
      logic exp_det;
      int   exp_cnt;
   } vec_t;

   vec_t tbl[$];

   initial begin
      vec_t t;
      logic [6:0] stream;
      logic [6:0] t1_det, t2_det;
      int         t1_cnt[7], t2_cnt[7];
      int         pulses;

      rst_n = 1'b0; v = 1'b0; b = 1'b0; ovl = 1'b0; ld = 1'b0; p = '0;
      s_rst = 1'b0; s_v = 1'b0; s_b = 1'b0; s_ovl = 1'b0;
      mpat = 4'b1011; fresh = 0; edet = 0; ecnt = 0;

      // T1/T2 table: stream 1,0,1,1,0,1,1 (first bit at index 6)
      stream = 7'b1011011;
      t1_det = 7'b0001000;
      t2_det = 7'b0001001;
      t1_cnt = '{0, 0, 0, 1, 1, 1, 1};
      t2_cnt = '{0, 0, 0, 1, 1, 1, 2};
      t = '{r:1'b0, vv:1'b0, bb:1'b0, oo:1'b0, exp_det:1'b0, exp_cnt:0};
      tbl.push_back(t);
      for (int i = 0; i < 7; i++) begin
         t = '{r:1'b1, vv:1'b1, bb:stream[6-i], oo:1'b0, exp_det:t1_det[6-i], exp_cnt:t1_cnt[i]};
         tbl.push_back(t);
      end
      t = '{r:1'b0, vv:1'b0, bb:1'b0, oo:1'b1, exp_det:1'b0, exp_cnt:0};
      tbl.push_back(t);
      for (int i = 0; i < 7; i++) begin
         t = '{r:1'b1, vv:1'b1, bb:stream[6-i], oo:1'b1, exp_det:t2_det[6-i], exp_cnt:t2_cnt[i]};
         tbl.push_back(t);
      end

      foreach (tbl[k]) begin
         step(tbl[k].r, tbl[k].vv, tbl[k].bb, tbl[k].oo, 1'b0, 4'b0000);
         chk($sformatf("tbl%0d_det", k), int'(det), int'(tbl[k].exp_det));
         chk($sformatf("tbl%0d_cnt", k), int'(cnt), tbl[k].exp_cnt);
      end

      // T3: gaps of in_valid=0 do not break a partial match
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      stream = 7'b0001011;
      for (int i = 0; i < 4; i++) begin
         bit_in(stream[3-i], 1'b0);
         chk("t3_bit_det", int'(det), (i == 3) ? 1 : 0);
         for (int g = 0; g < 3; g++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
            chk("t3_gap_det", int'(det), 0);
         end
      end
      chk("t3_cnt", int'(cnt), 1);

      // T4: reload with 1111 discards the old prefix
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
      chk("t4_load_det", int'(det), 0);
      for (int i = 0; i < 5; i++) begin
         bit_in(1'b1, 1'b1);
         chk("t4_det", int'(det), (i >= 3) ? 1 : 0);
      end
      chk("t4_cnt", int'(cnt), 2);

      // T6: reset mid-stream clears partial history
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
      chk("t6_rst_det", int'(det), 0);
      chk("t6_rst_cnt", int'(cnt), 0);
      bit_in(1'b1, 1'b0);
      chk("t6_nopulse", int'(det), 0);
      bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0); bit_in(1'b1, 1'b0);
      chk("t6_pulse", int'(det), 1);

      // T5: CNT_W=2 saturation, pattern 1111, ten ones with overlap
      v = 1'b0; ld = 1'b0;
      s_rst = 1'b0; s_v = 1'b0;
      @(posedge clk); #1;
      model_edge(rst_n, v, b, ovl, ld, p);
      chk("t5_rst_cnt", int'(s_cnt), 0);
      s_rst = 1'b1; s_v = 1'b1; s_b = 1'b1; s_ovl = 1'b1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         model_edge(rst_n, v, b, ovl, ld, p);
         if (s_det) pulses++;
         chk("t5_det", int'(s_det), (i >= 3) ? 1 : 0);
         chk("t5_cnt", int'(s_cnt), (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2));
      end
      chk("t5_pulses", pulses, 7);
      s_v = 1'b0;

      // Randomized traffic against the reference model
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(99) != 0), ($urandom_range(3) != 0), 1'($urandom),
              1'($urandom), ($urandom_range(49) == 0), 4'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
